// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, EX redirect squash,
// MDU freeze with watchdog, plus saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MDU_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_wb_load,
  input  logic             ex_redirect,
  input  logic             ex_mdu_start,
  input  logic             mdu_done,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_hold,
  output logic             mem_bubble,
  output logic             busy,
  output logic             mdu_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned WaitW = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MDU_TIMEOUT - 1);

  typedef enum logic [0:0] {StRun, StMdu} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic lu_hz;
  logic release_mdu;
  logic pc_stall_raw, if_id_stall_raw, if_id_flush_raw;
  logic id_ex_flush_raw, ex_hold_raw, mem_bubble_raw;

  assign lu_hz = ex_wb_load && (ex_rd != 5'd0) &&
                 ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

  assign release_mdu = mdu_done || (wait_cnt_q == WaitLast);

  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    timeout_d       = timeout_q;
    pc_stall_raw    = 1'b0;
    if_id_stall_raw = 1'b0;
    if_id_flush_raw = 1'b0;
    id_ex_flush_raw = 1'b0;
    ex_hold_raw     = 1'b0;
    mem_bubble_raw  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (ex_redirect) begin
          if_id_flush_raw = 1'b1;
          id_ex_flush_raw = 1'b1;
        end else if (ex_mdu_start && !mdu_done) begin
          pc_stall_raw    = 1'b1;
          if_id_stall_raw = 1'b1;
          ex_hold_raw     = 1'b1;
          mem_bubble_raw  = 1'b1;
          state_d         = StMdu;
          wait_cnt_d      = '0;
        end else if (ex_mdu_start) begin
          // Single-cycle MDU result: instruction flows through untouched.
        end else if (lu_hz) begin
          pc_stall_raw    = 1'b1;
          if_id_stall_raw = 1'b1;
          id_ex_flush_raw = 1'b1;
        end
      end
      StMdu: begin
        // EX is frozen, so redirects and load-use hazards cannot be acted on here.
        wait_cnt_d = wait_cnt_q + WaitW'(1);
        if (release_mdu) begin
          state_d = StRun;
          if (!mdu_done) timeout_d = 1'b1;
        end else begin
          pc_stall_raw    = 1'b1;
          if_id_stall_raw = 1'b1;
          ex_hold_raw     = 1'b1;
          mem_bubble_raw  = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Gate combinational controls so nothing leaks out while reset is held.
  always_comb begin
    pc_stall    = pc_stall_raw    && !rst;
    if_id_stall = if_id_stall_raw && !rst;
    if_id_flush = if_id_flush_raw && !rst;
    id_ex_flush = id_ex_flush_raw && !rst;
    ex_hold     = ex_hold_raw     && !rst;
    mem_bubble  = mem_bubble_raw  && !rst;
    busy        = (state_q == StMdu) && !rst;
    mdu_timeout = timeout_q;
    stall_count = stall_count_q;
    flush_count = flush_count_q;
  end

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (pc_stall && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);
    if (if_id_flush && (flush_count_q != '1)) flush_count_d = flush_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StRun;
      wait_cnt_q    <= '0;
      timeout_q     <= 1'b0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_q     <= timeout_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: dut_a uses default parameters, dut_b a short watchdog and 4-bit counters.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // dut_a stimulus/observation
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic        a_u1, a_u2, a_ld, a_redir, a_start, a_done;
  logic        a_pcs, a_ifs, a_iff, a_ief, a_hold, a_mb, a_busy, a_to;
  logic [31:0] a_sc, a_fc;

  // dut_b stimulus/observation
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic        b_u1, b_u2, b_ld, b_redir, b_start, b_done;
  logic        b_pcs, b_ifs, b_iff, b_ief, b_hold, b_mb, b_busy, b_to;
  logic [3:0]  b_sc, b_fc;

  pipeline_hazard_ctrl dut_a (
    .clk(clk), .rst(rst),
    .id_rs1(a_rs1), .id_rs2(a_rs2), .id_uses_rs1(a_u1), .id_uses_rs2(a_u2),
    .ex_rd(a_rd), .ex_wb_load(a_ld), .ex_redirect(a_redir), .ex_mdu_start(a_start),
    .mdu_done(a_done),
    .pc_stall(a_pcs), .if_id_stall(a_ifs), .if_id_flush(a_iff), .id_ex_flush(a_ief),
    .ex_hold(a_hold), .mem_bubble(a_mb), .busy(a_busy), .mdu_timeout(a_to),
    .stall_count(a_sc), .flush_count(a_fc)
  );

  pipeline_hazard_ctrl #(.CNT_W(4), .MDU_TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst),
    .id_rs1(b_rs1), .id_rs2(b_rs2), .id_uses_rs1(b_u1), .id_uses_rs2(b_u2),
    .ex_rd(b_rd), .ex_wb_load(b_ld), .ex_redirect(b_redir), .ex_mdu_start(b_start),
    .mdu_done(b_done),
    .pc_stall(b_pcs), .if_id_stall(b_ifs), .if_id_flush(b_iff), .id_ex_flush(b_ief),
    .ex_hold(b_hold), .mem_bubble(b_mb), .busy(b_busy), .mdu_timeout(b_to),
    .stall_count(b_sc), .flush_count(b_fc)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Checks the six control outputs of dut_a: {pcs, ifs, iff, ief, hold, mb}.
  task automatic chk_a(input string tag, input logic [5:0] exp);
    chkn(tag, {26'd0, a_pcs, a_ifs, a_iff, a_ief, a_hold, a_mb}, {26'd0, exp});
  endtask

  task automatic chk_b(input string tag, input logic [5:0] exp);
    chkn(tag, {26'd0, b_pcs, b_ifs, b_iff, b_ief, b_hold, b_mb}, {26'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_a();
    a_rs1 = 0; a_rs2 = 0; a_rd = 0; a_u1 = 0; a_u2 = 0;
    a_ld = 0; a_redir = 0; a_start = 0; a_done = 0;
  endtask

  task automatic clr_b();
    b_rs1 = 0; b_rs2 = 0; b_rd = 0; b_u1 = 0; b_u2 = 0;
    b_ld = 0; b_redir = 0; b_start = 0; b_done = 0;
  endtask

  initial begin
    clr_a();
    clr_b();
    rst = 1'b1;
    // Hazard, redirect and MDU inputs during reset must not reach outputs.
    a_ld = 1; a_rd = 5; a_rs1 = 5; a_u1 = 1; a_redir = 1;
    #2;
    chk_a("reset_ctrl_redirect", 6'b000000);
    a_redir = 0; a_start = 1;
    #1;
    chk_a("reset_ctrl_mdu", 6'b000000);
    chk1("reset_busy", a_busy, 1'b0);
    chk1("reset_timeout", a_to, 1'b0);
    chkn("reset_stall_count", a_sc, 0);
    chkn("reset_flush_count", a_fc, 0);
    clr_a();
    tick();
    rst = 1'b0;

    // Load-use on rs1
    a_ld = 1; a_rd = 5; a_rs1 = 5; a_u1 = 1;
    #2;
    chk_a("lu_rs1_ctrl", 6'b110100);
    tick();
    chkn("lu_rs1_stall_count", a_sc, 1);
    clr_a();
    #2;
    chk_a("lu_cleared", 6'b000000);

    // Load-use on rs2
    a_ld = 1; a_rd = 7; a_rs2 = 7; a_u2 = 1; a_rs1 = 3; a_u1 = 1;
    #2;
    chk_a("lu_rs2_ctrl", 6'b110100);
    tick();
    chkn("lu_rs2_stall_count", a_sc, 2);

    // No hazard: rd==x0, unused source, non-load producer
    clr_a(); a_ld = 1; a_rd = 0; a_rs1 = 0; a_u1 = 1;
    #2;
    chk_a("no_lu_x0", 6'b000000);
    tick();
    clr_a(); a_ld = 1; a_rd = 5; a_rs1 = 5; a_u1 = 0;
    #2;
    chk_a("no_lu_unused", 6'b000000);
    tick();
    clr_a(); a_ld = 0; a_rd = 5; a_rs1 = 5; a_u1 = 1;
    #2;
    chk_a("no_lu_nonload", 6'b000000);
    tick();
    chkn("no_lu_stall_count", a_sc, 2);
    chkn("no_lu_flush_count", a_fc, 0);

    // Redirect beats load-use and MDU start
    clr_a(); a_ld = 1; a_rd = 5; a_rs1 = 5; a_u1 = 1; a_redir = 1; a_start = 1;
    #2;
    chk_a("redirect_ctrl", 6'b001100);
    tick();
    clr_a();
    #2;
    chk1("redirect_busy", a_busy, 1'b0);
    chkn("redirect_flush_count", a_fc, 1);
    chkn("redirect_stall_count", a_sc, 2);

    // Single-cycle MDU result, load-use present but outranked
    a_start = 1; a_done = 1; a_ld = 1; a_rd = 5; a_rs1 = 5; a_u1 = 1;
    #2;
    chk_a("mdu_single_ctrl", 6'b000000);
    tick();
    clr_a();
    #2;
    chk1("mdu_single_busy", a_busy, 1'b0);

    // Multi-cycle MDU: start at T, done at T+33
    a_start = 1; a_ld = 1; a_rd = 5; a_rs1 = 5; a_u1 = 1;
    #2;
    chk_a("mdu_T_ctrl", 6'b110011);
    chk1("mdu_T_busy", a_busy, 1'b0);
    tick();
    clr_a(); a_redir = 1; a_ld = 1; a_rd = 5; a_rs1 = 5; a_u1 = 1;
    for (int k = 1; k <= 32; k++) begin
      #2;
      chk_a("mdu_wait_ctrl", 6'b110011);
      chk1("mdu_wait_busy", a_busy, 1'b1);
      tick();
    end
    a_done = 1;
    #2;
    chk_a("mdu_done_ctrl", 6'b000000);
    chk1("mdu_done_busy", a_busy, 1'b1);
    tick();
    clr_a();
    #2;
    chk1("mdu_after_busy", a_busy, 1'b0);
    chkn("mdu_stall_count", a_sc, 35);
    chkn("mdu_flush_count", a_fc, 1);
    chk1("mdu_no_timeout", a_to, 1'b0);

    // Reset mid-op at T+5
    a_start = 1;
    tick();
    clr_a();
    repeat (4) tick();
    chk1("mid_op_busy", a_busy, 1'b1);
    rst = 1'b1;
    #1;
    chk_a("mid_rst_ctrl", 6'b000000);
    chk1("mid_rst_busy", a_busy, 1'b0);
    chkn("mid_rst_stall_count", a_sc, 0);
    tick();
    rst = 1'b0;
    a_ld = 1; a_rd = 9; a_rs2 = 9; a_u2 = 1;
    #2;
    chk_a("post_rst_lu_ctrl", 6'b110100);
    tick();
    clr_a();
    chkn("post_rst_stall_count", a_sc, 1);
    chk1("post_rst_busy", a_busy, 1'b0);

    // Watchdog on dut_b (MDU_TIMEOUT=8): start at T, no done
    b_start = 1;
    #2;
    chk_b("to_T_ctrl", 6'b110011);
    tick();
    clr_b();
    for (int k = 1; k <= 7; k++) begin
      #2;
      chk_b("to_wait_ctrl", 6'b110011);
      chk1("to_wait_busy", b_busy, 1'b1);
      chk1("to_wait_flag", b_to, 1'b0);
      tick();
    end
    #2;
    chk_b("to_release_ctrl", 6'b000000);
    chk1("to_release_busy", b_busy, 1'b1);
    chk1("to_release_flag", b_to, 1'b0);
    tick();
    chk1("to_after_busy", b_busy, 1'b0);
    chk1("to_after_flag", b_to, 1'b1);
    chkn("to_stall_count", 32'(b_sc), 8);

    // Flag stays set across a normal op
    b_start = 1;
    tick();
    clr_b(); b_done = 1;
    #2;
    chk_b("to_op2_release", 6'b000000);
    tick();
    clr_b();
    chk1("to_sticky", b_to, 1'b1);
    chkn("to_op2_stall_count", 32'(b_sc), 9);

    // Counter saturation on 4-bit counters
    b_ld = 1; b_rd = 4; b_rs1 = 4; b_u1 = 1;
    repeat (10) tick();
    chk1("sat_lu_still_stalling", b_pcs, 1'b1);
    chkn("sat_stall_count", 32'(b_sc), 15);
    clr_b(); b_redir = 1;
    repeat (20) tick();
    chkn("sat_flush_count", 32'(b_fc), 15);
    clr_b();
    tick();
    chkn("sat_flush_hold", 32'(b_fc), 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
